// File: rtl/seq_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    // Default operand width when the divider is instantiated without overrides.
    localparam int DEF_WIDTH = 8;

    // Controller states: accept operands, iterate, apply signs, report.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Start/done handshake and result bus between a requester and seq_div.
interface seq_div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rem;
    logic             dbz;
    logic             ovf;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, signed_mode, in1, in2,
        input  busy, done, out, rem, dbz, ovf
    );

    // Divider side: consumes operands, drives status and results.
    modport slave (
        input  start, signed_mode, in1, in2,
        output busy, done, out, rem, dbz, ovf
    );

endinterface

// File: rtl/seq_div_step.sv
// One restoring-division iteration on the {R, Q} working register.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH:0] work_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [2*WIDTH:0] work_out
);

    // R after the left shift; one spare bit so the trial sign is exact.
    logic [WIDTH+1:0] r_shift;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH-1:0] q_shift;

    // Shift, trial-subtract the divisor, keep the difference only if it did not go negative.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        r_shift  = work_in[2*WIDTH:WIDTH-1];
        trial    = r_shift - {2'b00, divisor};
        fits     = ~trial[WIDTH+1];
        q_shift  = {work_in[WIDTH-2:0], fits};
        work_out = {r_shift[WIDTH:0], q_shift};
        if (fits) begin
            work_out = {trial[WIDTH:0], q_shift};
        end
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per clock.
module seq_div
    import div_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    seq_div_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    // Quotient magnitude that cannot be represented as a positive signed result.
    localparam logic [WIDTH-1:0] MIN_MAG   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   work;
    logic [2*WIDTH:0]   work_nxt;
    logic [WIDTH-1:0]   divisor;
    logic               sign_q;
    logic               sign_r;
    logic               sgn_mode;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   out_r;
    logic [WIDTH-1:0]   rem_r;
    logic               dbz_r;
    logic               ovf_r;

    // Absolute value in signed mode, raw value otherwise; -MIN wraps to the unsigned MIN_MAG.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
        return (sm && v[WIDTH-1]) ? -v : v;
    endfunction

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .work_in  (work),
        .divisor  (divisor),
        .work_out (work_nxt)
    );

    // Controller and datapath: capture, iterate WIDTH times, sign-fix, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            sgn_mode <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            out_r    <= '0;
            rem_r    <= '0;
            dbz_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every branch reads pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.in2 == '0) begin
                            // Divide-by-zero short-circuits straight to the report cycle.
                            out_r  <= '1;
                            rem_r  <= bus.in1;
                            dbz_r  <= 1'b1;
                            ovf_r  <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            work     <= {{(WIDTH+1){1'b0}}, magnitude(bus.in1, bus.signed_mode)};
                            divisor  <= magnitude(bus.in2, bus.signed_mode);
                            sign_q   <= bus.signed_mode & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                            sign_r   <= bus.signed_mode & bus.in1[WIDTH-1];
                            sgn_mode <= bus.signed_mode;
                            cnt      <= '0;
                            dbz_r    <= 1'b0;
                            ovf_r    <= 1'b0;
                            busy_r   <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    work <= work_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out_r  <= sign_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
                    rem_r  <= sign_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
                    ovf_r  <= sgn_mode & ~sign_q & (work[WIDTH-1:0] == MIN_MAG);
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;
    assign bus.rem  = rem_r;
    assign bus.dbz  = dbz_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases, handshake corners, reset abort, random ops.
module tb_seq_div;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [W-1:0] prev_out;

    seq_div_if #(.WIDTH(W)) bus ();

    seq_div #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer division of the operand values the mode implies.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        res_t res;
        int   sa;
        int   sb;
        int   q;
        int   r;
        if (b == 0) begin
            res.q   = '1;
            res.r   = a;
            res.dbz = 1'b1;
            res.ovf = 1'b0;
        end else begin
            sa = sm ? int'($signed(a)) : int'(a);
            sb = sm ? int'($signed(b)) : int'(b);
            q  = sa / sb;
            r  = sa % sb;
            res.q   = q[W-1:0];
            res.r   = r[W-1:0];
            res.dbz = 1'b0;
            res.ovf = sm && (q > 127);
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: issue, scramble inputs, wait for done, compare with the model.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input string tag);
        res_t e;
        int   cyc;
        int   busy_cyc;
        e = model(a, b, sm);
        tick();
        bus.start       = 1'b1;
        bus.in1         = a;
        bus.in2         = b;
        bus.signed_mode = sm;
        tick();
        bus.start       = 1'b0;
        bus.in1         = W'($urandom);
        bus.in2         = W'($urandom);
        bus.signed_mode = 1'($urandom);
        cyc      = 1;
        busy_cyc = 0;
        if (b != 0) begin
            check({tag, " dbz_clr"}, bus.dbz, 1'b0);
            check({tag, " out_hold"}, bus.out, prev_out);
        end
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cyc++;
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, (b == 0) ? 1 : W + 2);
        check({tag, " busy_cycles"}, busy_cyc, (b == 0) ? 0 : W + 1);
        check({tag, " busy_at_done"}, bus.busy, 1'b0);
        check({tag, " out"}, bus.out, e.q);
        check({tag, " rem"}, bus.rem, e.r);
        check({tag, " dbz"}, bus.dbz, e.dbz);
        check({tag, " ovf"}, bus.ovf, e.ovf);
        tick();
        check({tag, " done_pulse"}, bus.done, 1'b0);
        check({tag, " out_after"}, bus.out, e.q);
        prev_out = e.q;
    endtask

    initial begin
        int   n_done;
        int   done_cyc;
        logic seen_done;
        logic [W-1:0] got_out;
        logic [W-1:0] got_rem;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        checks          = 0;
        errors          = 0;
        prev_out        = '0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.in1         = '0;
        bus.in2         = '0;

        // Reset state.
        repeat (3) tick();
        check("rst busy", bus.busy, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst out",  bus.out,  '0);
        check("rst rem",  bus.rem,  '0);
        check("rst dbz",  bus.dbz,  1'b0);
        check("rst ovf",  bus.ovf,  1'b0);
        rst_n = 1'b1;

        // Directed cases.
        do_div(8'd100, 8'd7,  1'b0, "u100/7");
        do_div(8'hF9,  8'h02, 1'b1, "s-7/2");
        do_div(8'h07,  8'hFE, 1'b1, "s7/-2");
        do_div(8'd55,  8'd0,  1'b0, "u55/0");
        do_div(8'd9,   8'd3,  1'b0, "u9/3");
        do_div(8'd55,  8'd0,  1'b1, "s55/0");
        do_div(8'h80,  8'hFF, 1'b1, "s-128/-1");
        do_div(8'h80,  8'hFF, 1'b0, "u128/255");
        do_div(8'd0,   8'd5,  1'b1, "s0/5");
        do_div(8'hFF,  8'hFF, 1'b0, "u255/255");
        do_div(8'h80,  8'h01, 1'b1, "s-128/1");

        // start held high through a busy 255/1: one done, no queued restart.
        tick();
        bus.start       = 1'b1;
        bus.in1         = 8'hFF;
        bus.in2         = 8'h01;
        bus.signed_mode = 1'b0;
        tick();
        n_done   = 0;
        done_cyc = 0;
        got_out  = '0;
        got_rem  = '0;
        for (int c = 1; c <= W + 2; c++) begin
            if (bus.done) begin
                n_done++;
                done_cyc = c;
                got_out  = bus.out;
                got_rem  = bus.rem;
            end
            bus.in1 = W'($urandom);
            bus.in2 = W'($urandom | 1);
            if (c < W + 2) tick();
        end
        tick();
        bus.start = 1'b0;
        check("storm busy_after_done", bus.busy, 1'b0);
        check("storm done_once", bus.done, 1'b0);
        tick();
        check("storm no_queue", bus.busy, 1'b0);
        check("storm n_done", n_done, 1);
        check("storm latency", done_cyc, W + 2);
        check("storm out", got_out, 8'hFF);
        check("storm rem", got_rem, 8'h00);
        prev_out = 8'hFF;

        // Reset mid-operation on a 200/3.
        tick();
        bus.start       = 1'b1;
        bus.in1         = 8'd200;
        bus.in2         = 8'd3;
        bus.signed_mode = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 1'b0);
        check("abort out",  bus.out,  '0);
        check("abort rem",  bus.rem,  '0);
        check("abort dbz",  bus.dbz,  1'b0);
        check("abort ovf",  bus.ovf,  1'b0);
        seen_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        check("abort no_done", seen_done, 1'b0);
        prev_out = '0;
        do_div(8'd200, 8'd3, 1'b0, "u200/3");

        // Randomised operations, with occasional zero divisors and the overflow corner.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                ra = 8'h80;
                rb = 8'hFF;
            end
            do_div(ra, rb, 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Parametrised multi-cycle restoring divider; successor to the team's combinational 8-bit divider.
- Produces quotient and remainder at one quotient bit per clock, in signed or unsigned mode.
- Uses a start/done handshake and flags divide-by-zero and signed overflow.
- Sits beside the ALU datapath as a shared long-latency arithmetic unit.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (>=2)
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
in1  input  WIDTH  dividend, captured with start
in2  input  WIDTH  divisor, captured with start
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse; out/rem/dbz/ovf valid in this cycle and held afterwards
out  output  WIDTH  quotient
rem  output  WIDTH  remainder
dbz  output  1  divide-by-zero flag for the last result
ovf  output  1  signed overflow flag for the last result

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, dbz and ovf are 0; out and rem are 0; internal counter is 0.
  - Reset mid-operation abandons the division; no done pulse is issued.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1 at edge E0, latch signed_mode, in1 and in2.
  - If in2==0, go to DONE with out = all ones, rem = in1, dbz=1, ovf=0.
  - Otherwise load magnitudes into the working register: |in1| and |in2| in signed mode, raw values in unsigned mode. Record sign_q = sign(in1) XOR sign(in2) and sign_r = sign(in1). Clear the counter and go to CALC.
  - dbz and ovf for the new operation are cleared at E0 when in2!=0.
- CALC:
  - Working register is 2*WIDTH+1 bits {R, Q}.
  - Each edge: shift left by 1, trial-subtract the divisor from R (WIDTH+1 bits), restore if negative. The new Q LSB = 1 if the trial is non-negative, else 0.
  - Runs exactly WIDTH edges (E1..E_WIDTH), then goes to FIX.
- FIX (edge E_WIDTH+1):
  - Apply signs: out = sign_q ? -Q : Q; rem = sign_r ? -R : R. All arithmetic is modulo 2^WIDTH.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed-mode in1 = -2^(WIDTH-1) with in2 = -1 gives out = -2^(WIDTH-1), rem = 0, ovf=1.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then return to IDLE.
- Latency:
  - Normal division: done is high in the cycle following edge E_WIDTH+1, i.e. WIDTH+2 cycles after the start edge.
  - Divide-by-zero: done follows the start edge by 1 cycle.
- busy:
  - Asserted from E0 through the FIX state; deasserted in DONE.
- start while not in IDLE is ignored and is not queued.
- start sampled in the DONE cycle is ignored; the next accept is in IDLE.
- in1, in2 and signed_mode may change freely after capture without affecting the result.
- out, rem, dbz and ovf hold their values until the next done, even across start acceptance. Only dbz and ovf are updated at E0.
- Unsigned mode never sets ovf.

Decomposition:
- Package div_pkg holds the state typedef (IDLE, CALC, FIX, DONE) and a localparam for the default WIDTH.
- One natural sub-module, div_step: a combinational single restoring iteration with inputs {R, Q} and divisor, outputs next {R, Q}. It is instantiated once in seq_div.
- Sign handling and the FSM stay in seq_div.

Test Plan:
- Unsigned 100/7, WIDTH=8 -> out=14, rem=2, dbz=0, ovf=0; done exactly 10 cycles after the start edge; busy high 9 cycles.
- Signed -7/2 (in1=0xF9, in2=0x02) -> out=0xFD (-3), rem=0xFF (-1). Signed 7/-2 -> out=0xFD, rem=0x01.
- Divide-by-zero 55/0 (either mode) -> out=0xFF, rem=0x37, dbz=1; done 1 cycle after start. A following 9/3 clears dbz and gives out=3, rem=0.
- Signed -128/-1 (0x80/0xFF) -> out=0x80, rem=0, ovf=1. Unsigned 0x80/0xFF -> out=0, rem=0x80, ovf=0.
- start pulsed on every cycle during a busy 255/1 unsigned -> exactly one done, out=0xFF, rem=0. The second division starts only from IDLE.
- rst_n low at cycle 4 of a 200/3 -> all outputs 0 immediately (async), no done. After release, 200/3 -> out=66, rem=2.
